// File: rtl/fcs_check_rx.sv
// fcs_check_rx: bit-serial CRC-32 FCS checker.
// Recomputes CRC over the payload and compares it against the received FCS.
module fcs_check_rx #(
  parameter logic [31:0] STATE_INIT_VAL = 32'hFFFFFFFF,
  parameter logic [31:0] POLY           = 32'h04C11DB7,
  parameter int          LEN_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic             fcs_ok,
  output logic [5:0]       err_cnt,
  output logic [31:0]      crc_val
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_FCS  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [LEN_W:0]   r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_crc;
  logic [5:0]       r_err;
  logic             r_ok;

  logic             w_fb;
  logic [31:0]      w_crc_nxt;
  logic [LEN_W:0]   w_cnt_inc;
  logic             w_last_data;
  logic             w_last_fcs;
  logic [4:0]       w_idx;
  logic             w_mis;
  logic [5:0]       w_err_nxt;

  // Next-state helpers for the payload shift and FCS comparison
  always_comb begin
    w_fb        = r_crc[31] ^ s_in;
    w_crc_nxt   = {r_crc[30:0], 1'b0} ^ (w_fb ? POLY : 32'd0);
    w_cnt_inc   = r_cnt + (LEN_W+1)'(1);
    w_last_data = (w_cnt_inc == {1'b0, r_len});
    w_last_fcs  = (r_cnt[4:0] == 5'd31);
    w_idx       = 5'd31 - r_cnt[4:0];
    // received bit should equal the inverted CRC bit
    w_mis       = (s_in == r_crc[w_idx]);
    w_err_nxt   = r_err + {5'd0, w_mis};
  end

  // Frame sequencing, CRC accumulation and error counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_crc   <= STATE_INIT_VAL;
      r_err   <= '0;
      r_ok    <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_ok    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_crc   <= STATE_INIT_VAL;
            r_cnt   <= '0;
            r_err   <= '0;
            r_ok    <= 1'b0;
            r_len   <= len;
            r_state <= (len == '0) ? S_FCS : S_DATA;
          end
        end
        S_DATA: begin
          if (bit_valid) begin
            r_crc <= w_crc_nxt;
            if (w_last_data) begin
              r_cnt   <= '0;
              r_state <= S_FCS;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_FCS: begin
          if (bit_valid) begin
            r_err <= w_err_nxt;
            r_cnt <= w_cnt_inc;
            if (w_last_fcs) begin
              r_ok    <= (w_err_nxt == 6'd0);
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_DATA) || (r_state == S_FCS);
  assign done    = (r_state == S_DONE);
  assign fcs_ok  = r_ok;
  assign err_cnt = r_err;
  assign crc_val = r_crc;

endmodule

// File: tb/tb_fcs_check_rx.sv
// tb_fcs_check_rx: vectors, corner sequences and random frames
// checked against a long-division CRC reference.
module tb_fcs_check_rx;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        abort;
  logic        bit_valid;
  logic        s_in;
  logic        busy;
  logic        done;
  logic        fcs_ok;
  logic [5:0]  err_cnt;
  logic [31:0] crc_val;

  int checks = 0;
  int errors = 0;

  fcs_check_rx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .abort(abort), .bit_valid(bit_valid), .s_in(s_in),
    .busy(busy), .done(done), .fcs_ok(fcs_ok),
    .err_cnt(err_cnt), .crc_val(crc_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [63:0] pay;
    logic        use_model;
    logic [31:0] fcs;
    logic [31:0] flip;
    logic [31:0] e_crc;
    logic        e_ok;
    logic [5:0]  e_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of (payload * x^32 + init * x^n) mod (x^32 + POLY)
  function automatic logic [31:0] crc_model(input int n,
                                            input logic [63:0] pay);
    bit a[$];
    logic [31:0] r;
    for (int i = n - 1; i >= 0; i--) a.push_back(pay[i]);
    for (int i = 0; i < 32; i++) a.push_back(1'b0);
    for (int i = 0; i < 32; i++) a[i] = ~a[i];
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 0; j < 32; j++) a[i+1+j] ^= POLY[31-j];
    for (int j = 0; j < 32; j++) r[31-j] = a[n+j];
    return r;
  endfunction

  task automatic run_frame(input string tag, input int n,
                           input logic [63:0] pay,
                           input logic [31:0] fcs, input int stall_max,
                           input logic [31:0] e_crc, input logic e_ok,
                           input logic [5:0] e_err);
    logic early;
    logic b;
    early = 1'b0;
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < n + 32; i++) begin
      if (stall_max > 0) begin
        repeat ($urandom_range(1, stall_max)) begin
          tick();
          early |= done;
        end
      end
      b = (i < n) ? pay[n-1-i] : fcs[31-(i-n)];
      bit_valid = 1'b1;
      s_in      = b;
      tick();
      bit_valid = 1'b0;
      s_in      = 1'b0;
      if (i < n + 31) early |= done;
    end
    chk({tag, " early_done"}, {31'd0, early}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " fcs_ok"}, {31'd0, fcs_ok}, {31'd0, e_ok});
    chk({tag, " err_cnt"}, {26'd0, err_cnt}, {26'd0, e_err});
    chk({tag, " crc_val"}, crc_val, e_crc);
    tick();
    chk({tag, " done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " ok_hold"}, {31'd0, fcs_ok}, {31'd0, e_ok});
  endtask

  vec_t vt[4];

  initial begin
    logic [31:0] c;
    logic [31:0] fl;
    int n;
    logic [63:0] p;

    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    bit_valid = 1'b0; s_in = 1'b0;

    vt[0] = '{0, 64'h0, 1'b0, 32'h00000000, 32'h0,
              32'hFFFFFFFF, 1'b1, 6'd0};
    vt[1] = '{1, 64'h0, 1'b0, 32'h04C11DB6, 32'h0,
              32'hFB3EE249, 1'b1, 6'd0};
    vt[2] = '{1, 64'h1, 1'b0, 32'h00000001, 32'h0,
              32'hFFFFFFFE, 1'b1, 6'd0};
    vt[3] = '{16, 64'h1100, 1'b1, 32'h0, 32'h80000001,
              32'h0, 1'b0, 6'd2};

    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst ok", {31'd0, fcs_ok}, 32'd0);
    chk("rst err", {26'd0, err_cnt}, 32'd0);
    chk("rst crc", crc_val, 32'hFFFFFFFF);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      if (vt[i].use_model) begin
        c = crc_model(vt[i].n, vt[i].pay);
        run_frame($sformatf("vec%0d", i), vt[i].n, vt[i].pay,
                  ~c ^ vt[i].flip, 0, c, vt[i].e_ok, vt[i].e_err);
      end else begin
        run_frame($sformatf("vec%0d", i), vt[i].n, vt[i].pay,
                  vt[i].fcs, 0, vt[i].e_crc, vt[i].e_ok, vt[i].e_err);
      end
    end

    c = crc_model(16, 64'h1100);
    run_frame("good1100", 16, 64'h1100, ~c, 0, c, 1'b1, 6'd0);
    run_frame("stall1100", 16, 64'h1100, ~c, 5, c, 1'b1, 6'd0);

    // abort after 8 payload bits
    start = 1'b1; len = 16'd16;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; s_in = 1'(i);
      tick();
    end
    bit_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort ok", {31'd0, fcs_ok}, 32'd0);
    fl = 32'd0;
    repeat (4) begin
      tick();
      fl |= {31'd0, done};
    end
    chk("abort no_done", fl, 32'd0);
    run_frame("post_abort", 16, 64'h1100, ~c, 0, c, 1'b1, 6'd0);

    // async reset mid-FCS
    start = 1'b1; len = 16'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bit_valid = 1'b1; s_in = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst ok", {31'd0, fcs_ok}, 32'd0);
    chk("arst err", {26'd0, err_cnt}, 32'd0);
    chk("arst crc", crc_val, 32'hFFFFFFFF);
    #3;
    rst_n = 1'b1;
    fl = 32'd0;
    repeat (40) begin
      tick();
      fl |= {31'd0, done};
    end
    chk("arst no_done", fl, 32'd0);

    // start while busy must not relatch len
    start = 1'b1; len = 16'd16;
    tick();
    start = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i == 4) begin
        start = 1'b1; len = 16'd3;
      end
      bit_valid = 1'b1;
      s_in = (i < 16) ? p[0] : 1'b0;
      s_in = (i < 16) ? 1'(16'h1100 >> (15 - i)) : c[31-(i-16)] ^ 1'b1;
      tick();
      start = 1'b0;
      if (i == 46) chk("busy_start early", {31'd0, done}, 32'd0);
    end
    bit_valid = 1'b0;
    chk("busy_start done", {31'd0, done}, 32'd1);
    chk("busy_start ok", {31'd0, fcs_ok}, 32'd1);
    chk("busy_start crc", crc_val, c);
    tick();

    // random frames
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 64);
      p = {$urandom, $urandom};
      c = crc_model(n, p);
      fl = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
      run_frame($sformatf("rnd%0d", t), n, p, ~c ^ fl,
                int'($urandom_range(0, 3)), c, (fl == 32'd0),
                6'($countones(fl)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
